// File: rtl/sha_word_regbank_if.sv
// Handshake and data bundle between a word producer/consumer and sha_word_regbank.
// The master drives controls and words in; the slave (the register bank) returns the window.
interface sha_word_regbank_if #(
  parameter  int WIDTH     = 32,
  parameter  int NUM_WORDS = 16,
  localparam int CNT_W     = $clog2(NUM_WORDS + 1)
);
  logic                       start;
  logic [NUM_WORDS*WIDTH-1:0] data_i;
  logic                       shift_en;
  logic [WIDTH-1:0]           shift_i;
  logic                       clear;
  logic                       ready_i;
  logic [NUM_WORDS*WIDTH-1:0] data_o;
  logic [WIDTH-1:0]           head_o;
  logic [CNT_W-1:0]           fill_o;
  logic                       full_o;
  logic                       valid_o;

  modport master (
    output start, data_i, shift_en, shift_i, clear, ready_i,
    input  data_o, head_o, fill_o, full_o, valid_o
  );

  modport slave (
    input  start, data_i, shift_en, shift_i, clear, ready_i,
    output data_o, head_o, fill_o, full_o, valid_o
  );
endinterface

// File: rtl/sha_word_regbank.sv
// Sliding word window for the SHA-256 message schedule: parallel load, serial shift-in,
// clear and hold, with a fill counter and a valid/ready handshake towards the round engine.
module sha_word_regbank #(
  parameter  int WIDTH     = 32,
  parameter  int NUM_WORDS = 16,
  localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input logic                CLK,
  input logic                RST,
  sha_word_regbank_if.slave  bus
);

  localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(NUM_WORDS);

  logic [WIDTH-1:0] lanes_q [NUM_WORDS];
  logic [WIDTH-1:0] lanes_d [NUM_WORDS];
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             valid_q, valid_d;
  logic             accept;

  assign accept = bus.ready_i & valid_q;

  always_comb begin
    lanes_d = lanes_q;
    fill_d  = fill_q;
    valid_d = valid_q;

    if (bus.clear) begin
      for (int k = 0; k < NUM_WORDS; k++) lanes_d[k] = '0;
      fill_d  = '0;
      valid_d = 1'b0;
    end else if (bus.start) begin
      for (int k = 0; k < NUM_WORDS; k++) lanes_d[k] = bus.data_i[k*WIDTH +: WIDTH];
      fill_d  = FILL_FULL;
      valid_d = 1'b1;
    end else if (bus.shift_en) begin
      for (int k = 0; k < NUM_WORDS - 1; k++) lanes_d[k] = lanes_q[k+1];
      lanes_d[NUM_WORDS-1] = bus.shift_i;
      // An accepted window restarts counting from the word shifted in this cycle.
      if (accept)                 fill_d = CNT_W'(1);
      else if (fill_q != FILL_FULL) fill_d = fill_q + CNT_W'(1);
      valid_d = !accept && (fill_d == FILL_FULL);
    end else if (accept) begin
      fill_d  = '0;
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the lane array is reset too because a cleared window must read as zero.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int k = 0; k < NUM_WORDS; k++) lanes_q[k] <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
    end
  end

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_pack
    assign bus.data_o[k*WIDTH +: WIDTH] = lanes_q[k];
  end

  assign bus.head_o  = lanes_q[0];
  assign bus.fill_o  = fill_q;
  assign bus.full_o  = (fill_q == FILL_FULL);
  assign bus.valid_o = valid_q;

endmodule

// File: doc/sha_word_regbank.md
Name: sha_word_regbank

Overview:
Parametrised word register bank for the SHA-256 datapath, the successor to the fixed 4-word start-loaded register. It holds NUM_WORDS words of WIDTH bits and supports parallel load, serial shift-in as a sliding window (message schedule W[t-16..t-1]), clear, and hold. It adds a fill counter and a valid/ready handshake so the round engine knows when a complete window is present. It sits between the message padder/input buffer and the schedule/compression logic.

Parameters:
WIDTH, 32, bits per word
NUM_WORDS, 16, number of word lanes; must be >= 2
CNT_W, derived as clog2(NUM_WORDS+1), width of fill counter; not overridden by user

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-low reset
start  input  1  parallel load of all lanes from data_i
data_i  input  NUM_WORDS*WIDTH  parallel load data; lane k = data_i[k*WIDTH +: WIDTH]
shift_en  input  1  shift window by one word, insert shift_i
shift_i  input  WIDTH  word inserted at top lane on shift
clear  input  1  zero all lanes and state
ready_i  input  1  consumer accepts current window
data_o  output  NUM_WORDS*WIDTH  all lanes; lane k = data_o[k*WIDTH +: WIDTH]
head_o  output  WIDTH  lane 0 (oldest word)
fill_o  output  CNT_W  number of valid words, 0..NUM_WORDS
full_o  output  1  fill_o == NUM_WORDS
valid_o  output  1  complete window available to consumer

Behaviour:
- One clock, CLK. Reset is synchronous and active-low: RST sampled low at a rising CLK edge -> all lanes 0, fill_o 0, full_o 0, valid_o 0. RST has no asynchronous effect.
- All outputs are registered; every input takes effect at the next rising edge (1-cycle latency). head_o, full_o are decodes of registered state, not extra delay.
- Priority per edge: RST low > clear > start > shift_en > hold.
- clear: all lanes 0, fill 0, valid 0. Any ready_i, start, or shift_en in the same cycle is ignored.
- start: lane k <= data_i lane k for all k; fill <= NUM_WORDS; valid <= 1. shift_en and ready_i in the same cycle are ignored (new window replaces any unaccepted one).
- shift_en (no clear/start): lane k <= lane k+1 for k < NUM_WORDS-1; lane NUM_WORDS-1 <= shift_i. Lane 0 content is discarded.
  - fill increments, saturating at NUM_WORDS. valid <= 1 when the new fill == NUM_WORDS.
  - Shifting while full is legal (sliding window): fill stays NUM_WORDS, valid stays 1 unless accepted this cycle.
- Accept: ready_i & valid_o (no clear/start) -> fill <= 0, valid <= 0; lane data retained. Accept with shift_en in the same cycle: the shift happens, fill <= 1, valid <= 0.
- ready_i while valid_o == 0: no effect.
- Hold (no control active): all state unchanged.
- fill_o never exceeds NUM_WORDS; no wrap-around.
- full_o == (fill_o == NUM_WORDS) at all times. valid_o implies full_o. After an accept, full_o drops with fill_o.
- Reset mid-fill or while valid: state returns to reset values at that edge. Inputs are ignored during that cycle.

Test Plan:
- Reset: drive random state, hold RST=0 one edge -> data_o=0, fill_o=0, full_o=0, valid_o=0; RST=1 with no controls -> values hold.
- Parallel load: start=1, lane k = 32'h6A09E667+k -> next cycle data_o matches, fill_o=16, full_o=1, valid_o=1; start=0 -> hold.
- Serial fill: 16 shifts with shift_i = 1..16 -> fill_o steps 1..16; valid_o rises on the cycle after the 16th shift; head_o=1, lane 15=16.
- Sliding window: from full, shift_i=17 -> head_o=2, lane 15=17, fill_o=16, valid_o=1; shift with ready_i=1 same cycle -> fill_o=1, valid_o=0, data shifted.
- Handshake/priority: valid_o=1 with ready_i=1 -> fill_o=0, valid_o=0, data unchanged; start+ready_i together -> valid_o=1, fill_o=16; clear+start together -> all zero.
- Mid-operation reset: after 7 shifts, RST=0 with shift_en=1 -> fill_o=0, lanes 0; refill of 16 words -> valid_o=1 after 16 shifts, not 9.
